// File: rtl/wb_sharedbus_arbiter.sv
// Round-robin owner selection for the shared Wishbone bus, plus a watchdog that
// terminates accesses nobody acknowledges so a hung slave cannot lock a master.
module wb_sharedbus_arbiter #(
    parameter int NUMM    = 3,
    parameter int TIMEOUT = 1024,
    parameter int CNTW    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUMM-1:0]         cyc_i,
    input  logic [NUMM-1:0]         stb_i,
    input  logic                    ack_i,
    input  logic                    err_i,
    output logic [NUMM-1:0]         gnt_o,
    output logic [$clog2(NUMM)-1:0] gnt_idx_o,
    output logic                    gnt_valid_o,
    output logic                    tout_err_o,
    output logic [CNTW-1:0]         tout_cnt_o
);

    localparam int IDXW    = $clog2(NUMM);
    localparam int WDW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit WD_ON   = (TIMEOUT != 0);
    localparam int WD_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    localparam logic [IDXW:0]    NUMM_W    = (IDXW + 1)'(NUMM);
    localparam logic [WDW-1:0]   WD_LAST_W = WDW'(WD_LAST);
    localparam logic [IDXW-1:0]  LAST_INIT = IDXW'(NUMM - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_TERM
    } state_t;

    state_t           r_state;
    logic [NUMM-1:0]  r_gnt;
    logic [IDXW-1:0]  r_idx;
    logic             r_valid;
    logic [IDXW-1:0]  r_last;
    logic [WDW-1:0]   r_wd;
    logic [CNTW-1:0]  r_cnt;

    logic [IDXW-1:0]  w_pos [NUMM];
    logic [NUMM-1:0]  w_req_rot;
    logic [IDXW-1:0]  w_pick;
    logic [NUMM-1:0]  w_pick_oh;
    logic             w_cyc_g;
    logic             w_wd_cond;
    logic             w_wd_hit;
    logic             w_tout_err;

    // Slot gi of the scan holds master (last + 1 + gi) mod NUMM.
    genvar gi;
    generate
        for (gi = 0; gi < NUMM; gi++) begin : g_scan
            logic [IDXW:0] w_sum;
            assign w_sum         = {1'b0, r_last} + (IDXW + 1)'(gi + 1);
            assign w_pos[gi]     = IDXW'((w_sum >= NUMM_W) ? w_sum - NUMM_W : w_sum);
            assign w_req_rot[gi] = cyc_i[w_pos[gi]];
            assign w_pick_oh[gi] = (w_pick == IDXW'(gi));
        end
    endgenerate

    always_comb begin
        w_pick = '0;
        for (int k = NUMM - 1; k >= 0; k--) begin
            if (w_req_rot[k]) begin
                w_pick = w_pos[k];
            end
        end
    end

    assign w_cyc_g    = cyc_i[r_idx];
    assign w_wd_cond  = w_cyc_g & stb_i[r_idx] & ~ack_i & ~err_i;
    assign w_wd_hit   = WD_ON && w_wd_cond && (r_wd == WD_LAST_W);
    // A real ack/err arriving in the termination cycle wins over the forced error.
    assign w_tout_err = (r_state == S_TERM) & ~ack_i & ~err_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_last  <= LAST_INIT;
            r_wd    <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_wd <= '0;
                    if (|cyc_i) begin
                        r_gnt   <= w_pick_oh;
                        r_idx   <= w_pick;
                        r_valid <= 1'b1;
                        r_last  <= w_pick;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (!w_cyc_g) begin
                        r_gnt   <= '0;
                        r_idx   <= '0;
                        r_valid <= 1'b0;
                        r_wd    <= '0;
                        r_state <= S_IDLE;
                    end else if (w_wd_hit) begin
                        r_wd    <= '0;
                        r_state <= S_TERM;
                    end else if (w_wd_cond) begin
                        r_wd <= r_wd + 1'b1;
                    end else begin
                        r_wd <= '0;
                    end
                end
                S_TERM: begin
                    r_wd <= '0;
                    if (w_tout_err && (r_cnt != '1)) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (w_cyc_g) begin
                        r_state <= S_GRANT;
                    end else begin
                        r_gnt   <= '0;
                        r_idx   <= '0;
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_gnt   <= '0;
                    r_idx   <= '0;
                    r_valid <= 1'b0;
                    r_wd    <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt_o       = r_gnt;
    assign gnt_idx_o   = r_idx;
    assign gnt_valid_o = r_valid;
    assign tout_err_o  = w_tout_err;
    assign tout_cnt_o  = r_cnt;

endmodule

// File: tb/tb_wb_sharedbus_arbiter.sv
// Directed bench for wb_sharedbus_arbiter: an owner/stall-count model checked every
// cycle, plus hand-computed expectations for round robin, timeout and reset cases.
module tb_wb_sharedbus_arbiter;

    localparam int NUMM    = 3;
    localparam int TIMEOUT = 16;
    localparam int CNTW    = 2;
    localparam int CMAX    = (1 << CNTW) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NUMM-1:0]  cyc_i = '0;
    logic [NUMM-1:0]  stb_i = '0;
    logic             ack_i = 1'b0;
    logic             err_i = 1'b0;
    logic [NUMM-1:0]  gnt_o;
    logic [1:0]       gnt_idx_o;
    logic             gnt_valid_o;
    logic             tout_err_o;
    logic [CNTW-1:0]  tout_cnt_o;

    int errors = 0;
    int checks = 0;

    wb_sharedbus_arbiter #(
        .NUMM    (NUMM),
        .TIMEOUT (TIMEOUT),
        .CNTW    (CNTW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cyc_i       (cyc_i),
        .stb_i       (stb_i),
        .ack_i       (ack_i),
        .err_i       (err_i),
        .gnt_o       (gnt_o),
        .gnt_idx_o   (gnt_idx_o),
        .gnt_valid_o (gnt_valid_o),
        .tout_err_o  (tout_err_o),
        .tout_cnt_o  (tout_cnt_o)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endfunction

    // Model: who owns the bus, how many consecutive unanswered strobes it has
    // made, whether this cycle is the forced-termination cycle, and the tally.
    int m_owner = -1;
    int m_last  = NUMM - 1;
    int m_stall = 0;
    int m_cnt   = 0;
    bit m_term  = 1'b0;
    bit m_live  = 1'b0;

    always @(posedge clk) begin
        m_live = 1'b1;
        if (rst) begin
            m_owner = -1;
            m_last  = NUMM - 1;
            m_stall = 0;
            m_cnt   = 0;
            m_term  = 1'b0;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= NUMM; k++) begin
                int c;
                c = (m_last + k) % NUMM;
                if (m_owner < 0 && cyc_i[c]) begin
                    m_owner = c;
                    m_last  = c;
                    m_stall = 0;
                end
            end
        end else if (m_term) begin
            if (!ack_i && !err_i && m_cnt < CMAX) m_cnt = m_cnt + 1;
            m_term  = 1'b0;
            m_stall = 0;
            if (!cyc_i[m_owner]) m_owner = -1;
        end else begin
            if (!cyc_i[m_owner]) begin
                m_owner = -1;
                m_stall = 0;
            end else if (stb_i[m_owner] && !ack_i && !err_i) begin
                m_stall = m_stall + 1;
                if (TIMEOUT != 0 && m_stall == TIMEOUT) begin
                    m_term  = 1'b1;
                    m_stall = 0;
                end
            end else begin
                m_stall = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("cyc_gnt",   int'(gnt_o),       (m_owner >= 0) ? (1 << m_owner) : 0);
            chk("cyc_idx",   int'(gnt_idx_o),   (m_owner >= 0) ? m_owner : 0);
            chk("cyc_valid", int'(gnt_valid_o), (m_owner >= 0) ? 1 : 0);
            chk("cyc_terr",  int'(tout_err_o),  (m_term && !ack_i && !err_i) ? 1 : 0);
            chk("cyc_tcnt",  int'(tout_cnt_o),  m_cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        // Reset
        rst = 1'b1;
        tick();
        chk("rst_valid", int'(gnt_valid_o), 0);
        chk("rst_cnt", int'(tout_cnt_o), 0);
        tick();
        rst = 1'b0;

        // Round robin with all masters requesting, each holding 2 cycles
        cyc_i = 3'b111;
        for (int r = 0; r < 6; r++) begin
            int n;
            n = 0;
            while (!gnt_valid_o && n < 8) begin
                tick();
                n++;
            end
            chk("rr_latency", n, 1);
            chk("rr_owner", int'(gnt_idx_o), r % 3);
            $display("rr grant %0d -> master %0d", r, gnt_idx_o);
            tick();
            tick();
            cyc_i = 3'b111 & ~(3'b001 << (r % 3));
            tick();
            cyc_i = 3'b111;
            chk("rr_dead", int'(gnt_valid_o), 0);
        end
        cyc_i = '0;
        tick();
        tick();

        // stb without cyc never wins arbitration
        stb_i = 3'b111;
        tick();
        tick();
        chk("stb_only", int'(gnt_valid_o), 0);
        stb_i = '0;

        // Single request from master 2
        cyc_i = 3'b100;
        tick();
        chk("single_gnt", int'(gnt_o), 4);
        chk("single_idx", int'(gnt_idx_o), 2);
        tick();
        cyc_i = '0;
        chk("single_hold", int'(gnt_valid_o), 1);
        tick();
        chk("single_drop", int'(gnt_o), 0);
        chk("single_idx0", int'(gnt_idx_o), 0);
        tick();
        $display("single request done");

        // Timeout with stb held and no ack
        cyc_i = 3'b001;
        stb_i = 3'b001;
        tick();
        chk("to_owner", int'(gnt_idx_o), 0);
        repeat (15) tick();
        chk("to_early", int'(tout_err_o), 0);
        tick();
        chk("to_fire", int'(tout_err_o), 1);
        tick();
        chk("to_once", int'(tout_err_o), 0);
        chk("to_cnt", int'(tout_cnt_o), 1);
        chk("to_keep", int'(gnt_valid_o), 1);
        $display("timeout fired, count %0d", tout_cnt_o);

        // Ack arriving in the termination cycle suppresses the error
        repeat (16) tick();
        ack_i = 1'b1;
        #1;
        chk("late_ack", int'(tout_err_o), 0);
        tick();
        ack_i = 1'b0;
        chk("late_ack_cnt", int'(tout_cnt_o), 1);
        cyc_i = '0;
        stb_i = '0;
        tick();
        tick();
        $display("late ack done");

        // Saturation of the 2-bit timeout counter
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        cyc_i = 3'b010;
        stb_i = 3'b010;
        tick();
        chk("sat_owner", int'(gnt_idx_o), 1);
        repeat (35) tick();
        chk("sat_two", int'(tout_cnt_o), 2);
        repeat (51) tick();
        chk("sat_three", int'(tout_cnt_o), 3);
        $display("saturation done, count %0d", tout_cnt_o);

        // Reset while master 1 owns the bus mid-timeout
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", int'(gnt_valid_o), 0);
        chk("mid_rst_gnt", int'(gnt_o), 0);
        chk("mid_rst_idx", int'(gnt_idx_o), 0);
        chk("mid_rst_cnt", int'(tout_cnt_o), 0);
        chk("mid_rst_terr", int'(tout_err_o), 0);
        rst = 1'b0;
        cyc_i = 3'b011;
        stb_i = '0;
        tick();
        chk("post_rst_idx", int'(gnt_idx_o), 0);
        chk("post_rst_valid", int'(gnt_valid_o), 1);
        cyc_i = '0;
        tick();
        tick();
        $display("reset mid-transfer done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
